// File: rtl/path_tracer_pkg.sv
// Shared constants and FSM encoding for the shortest-path solver and the path tracer.
// Keeping them here lets both blocks agree on graph size and node width.
package path_tracer_pkg;

    localparam int unsigned N_NODES = 13;
    localparam int unsigned NODE_W  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWalk,
        StEmit
    } state_e;

endpackage

// File: rtl/path_stack.sv
// LIFO holding the nodes collected while walking predecessors back from the destination.
// Popping from the top yields the path in source-to-destination order.
module path_stack #(
    parameter int unsigned Depth = 13,
    parameter int unsigned Width = 4,
    localparam int unsigned PtrW = $clog2(Depth + 1),
    localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] top_data_o,
    output logic [IdxW-1:0]  top_idx_o,
    output logic             empty_o
);
    import path_tracer_pkg::*;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  ptr_q;
    logic             full;

    assign full       = (ptr_q == PtrW'(Depth));
    assign empty_o    = (ptr_q == '0);
    assign top_idx_o  = IdxW'(ptr_q - PtrW'(1));
    assign top_data_o = empty_o ? '0 : mem_q[top_idx_o];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_i) begin
            ptr_q <= '0;
        end else if (push_i && !full) begin
            mem_q[ptr_q] <= data_i;
            ptr_q        <= ptr_q + PtrW'(1);
        end else if (pop_i && !empty_o) begin
            ptr_q <= ptr_q - PtrW'(1);
        end
    end

endmodule

// File: rtl/path_tracer.sv
// Reconstructs a shortest path from a predecessor table by walking back from the destination,
// stacking nodes, then streaming them source-first over a valid/ready interface.
module path_tracer #(
    parameter int unsigned N_NODES = path_tracer_pkg::N_NODES,
    parameter int unsigned NODE_W  = path_tracer_pkg::NODE_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pred_we_i,
    input  logic [NODE_W-1:0] pred_waddr_i,
    input  logic [NODE_W-1:0] pred_wdata_i,
    input  logic              start_i,
    input  logic [NODE_W-1:0] start_node_i,
    input  logic [NODE_W-1:0] end_node_i,
    output logic              busy_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [NODE_W-1:0] out_node_o,
    output logic              out_last_o,
    output logic [NODE_W-1:0] path_len_o,
    output logic              err_o
);
    import path_tracer_pkg::*;

    localparam int unsigned IdxW = (N_NODES > 1) ? $clog2(N_NODES) : 1;

    state_e            state_q;
    logic [NODE_W-1:0] pred_q [N_NODES];
    logic [NODE_W-1:0] cur_q;
    logic [NODE_W-1:0] start_q;
    logic [NODE_W:0]   depth_q;
    logic [NODE_W:0]   depth_inc;
    logic              busy_q;
    logic              out_valid_q;
    logic              err_q;
    logic [NODE_W-1:0] path_len_q;

    logic              cur_ok;
    logic              waddr_ok;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_clr;
    logic [NODE_W-1:0] stk_top;
    logic [IdxW-1:0]   stk_idx;
    logic              stk_empty;
    logic              at_last;

    assign cur_ok    = (32'(cur_q) < N_NODES);
    assign waddr_ok  = (32'(pred_waddr_i) < N_NODES);
    assign depth_inc = depth_q + (NODE_W + 1)'(1);
    assign at_last   = !stk_empty && (stk_idx == '0);

    assign stk_clr  = (state_q == StIdle) && start_i;
    assign stk_push = (state_q == StWalk) && cur_ok;
    assign stk_pop  = (state_q == StEmit) && out_ready_i;

    path_stack #(
        .Depth (N_NODES),
        .Width (NODE_W)
    ) u_stack (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (stk_clr),
        .push_i     (stk_push),
        .pop_i      (stk_pop),
        .data_i     (cur_q),
        .top_data_o (stk_top),
        .top_idx_o  (stk_idx),
        .empty_o    (stk_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            start_q     <= '0;
            depth_q     <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            path_len_q  <= '0;
            for (int i = 0; i < N_NODES; i++) begin
                pred_q[i] <= '0;
            end
        end else begin
            err_q <= 1'b0;
            // The solver may only update the table while no trace is reading it
            if (pred_we_i && !busy_q && waddr_ok) begin
                pred_q[pred_waddr_i] <= pred_wdata_i;
            end
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StWalk;
                        busy_q  <= 1'b1;
                        start_q <= start_node_i;
                        cur_q   <= end_node_i;
                        depth_q <= '0;
                    end
                end
                StWalk: begin
                    if (!cur_ok) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        depth_q <= depth_inc;
                        if (cur_q == start_q) begin
                            state_q     <= StEmit;
                            out_valid_q <= 1'b1;
                            path_len_q  <= NODE_W'(depth_inc);
                        end else if (32'(depth_inc) == N_NODES) begin
                            // Stack full without reaching the source: cyclic or unreachable
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            cur_q <= pred_q[cur_q];
                        end
                    end
                end
                StEmit: begin
                    if (out_ready_i && at_last) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                        path_len_q  <= '0;
                        depth_q     <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign out_valid_o = out_valid_q;
    assign err_o       = err_q;
    assign path_len_o  = path_len_q;
    assign out_node_o  = out_valid_q ? stk_top : '0;
    assign out_last_o  = out_valid_q && at_last;

endmodule

// File: tb/tb_path_tracer.sv
// Directed bench for path_tracer: linear path, backpressure, trivial path, cycle detection,
// invalid node, blocked table writes and asynchronous reset during emission.
module tb_path_tracer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pred_we;
    logic [3:0] pred_waddr;
    logic [3:0] pred_wdata;
    logic       start;
    logic [3:0] start_node;
    logic [3:0] end_node;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_node;
    logic       out_last;
    logic [3:0] path_len;
    logic       err;

    int errors = 0;
    int checks = 0;

    logic [3:0] beat_node [16];
    logic       beat_last [16];
    logic [3:0] beat_len  [16];
    int         beat_n;
    int         held_bad;
    bit         got_last;
    logic [3:0] exp_lin [5];

    always #5 clk = ~clk;

    path_tracer #(
        .N_NODES (13),
        .NODE_W  (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pred_we_i    (pred_we),
        .pred_waddr_i (pred_waddr),
        .pred_wdata_i (pred_wdata),
        .start_i      (start),
        .start_node_i (start_node),
        .end_node_i   (end_node),
        .busy_o       (busy),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_node_o   (out_node),
        .out_last_o   (out_last),
        .path_len_o   (path_len),
        .err_o        (err)
    );

    task automatic write_pred(input logic [3:0] addr, input logic [3:0] data);
        pred_we    = 1'b1;
        pred_waddr = addr;
        pred_wdata = data;
        @(posedge clk); #1;
        pred_we    = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] s, input logic [3:0] e);
        start      = 1'b1;
        start_node = s;
        end_node   = e;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    // Records accepted beats; optionally toggles out_ready every cycle.
    task automatic collect(input bit toggle, input int max_cyc);
        logic [3:0] hold;
        bit         have_hold;
        beat_n    = 0;
        held_bad  = 0;
        got_last  = 1'b0;
        have_hold = 1'b0;
        hold      = '0;
        for (int c = 0; c < max_cyc && !got_last; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (have_hold && out_node !== hold) held_bad++;
                if (out_ready) begin
                    if (beat_n < 16) begin
                        beat_node[beat_n] = out_node;
                        beat_last[beat_n] = out_last;
                        beat_len[beat_n]  = path_len;
                    end
                    beat_n++;
                    have_hold = 1'b0;
                    if (out_last) got_last = 1'b1;
                end else begin
                    hold      = out_node;
                    have_hold = 1'b1;
                end
            end
            @(posedge clk); #1;
            if (toggle) out_ready = ~out_ready;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pred_we = 1'b0; pred_waddr = '0; pred_wdata = '0;
        start = 1'b0; start_node = '0; end_node = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, out_valid, out_last, err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, out_valid, out_last, err});
        end
        checks++;
        if (out_node !== 4'd0 || path_len !== 4'd0) begin
            errors++; $display("FAIL reset_data: node=%0d len=%0d expected 0/0", out_node, path_len);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_linear();
        write_pred(4'd2, 4'd0);
        write_pred(4'd0, 4'd1);
        write_pred(4'd1, 4'd4);
        write_pred(4'd4, 4'd10);
        out_ready = 1'b1;
        do_start(4'd10, 4'd2);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL lin_busy: got %b expected 1", busy);
        end
        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if (out_valid !== 1'b0 || out_node !== 4'd0) begin
            errors++; $display("FAIL lin_early_valid: valid=%b node=%0d expected 0/0", out_valid, out_node);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL lin_latency: out_valid=%b expected 1 after 5 walk cycles", out_valid);
        end
        collect(1'b0, 12);
        checks++;
        if (beat_n !== 5) begin
            errors++; $display("FAIL lin_count: got %0d beats expected 5", beat_n);
        end
        for (int i = 0; i < 5 && i < beat_n; i++) begin
            checks++;
            if (beat_node[i] !== exp_lin[i] || beat_last[i] !== (i == 4) || beat_len[i] !== 4'd5) begin
                errors++;
                $display("FAIL lin_beat%0d: node=%0d last=%b len=%0d expected %0d/%b/5",
                         i, beat_node[i], beat_last[i], beat_len[i], exp_lin[i], (i == 4));
            end
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || path_len !== 4'd0) begin
            errors++;
            $display("FAIL lin_done: busy=%b valid=%b len=%0d expected 0/0/0", busy, out_valid, path_len);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        do_start(4'd10, 4'd2);
        collect(1'b1, 40);
        out_ready = 1'b1;
        checks++;
        if (beat_n !== 5) begin
            errors++; $display("FAIL bp_count: got %0d beats expected 5", beat_n);
        end
        for (int i = 0; i < 5 && i < beat_n; i++) begin
            checks++;
            if (beat_node[i] !== exp_lin[i] || beat_last[i] !== (i == 4)) begin
                errors++;
                $display("FAIL bp_beat%0d: node=%0d last=%b expected %0d/%b",
                         i, beat_node[i], beat_last[i], exp_lin[i], (i == 4));
            end
        end
        checks++;
        if (held_bad !== 0) begin
            errors++; $display("FAIL bp_hold: %0d changes while stalled expected 0", held_bad);
        end
    endtask

    task automatic test_trivial();
        out_ready = 1'b1;
        do_start(4'd7, 4'd7);
        collect(1'b0, 10);
        checks++;
        if (beat_n !== 1 || beat_node[0] !== 4'd7 || beat_last[0] !== 1'b1 || beat_len[0] !== 4'd1) begin
            errors++;
            $display("FAIL triv_beat: n=%0d node=%0d last=%b len=%0d expected 1/7/1/1",
                     beat_n, beat_node[0], beat_last[0], beat_len[0]);
        end
    endtask

    task automatic test_cycle();
        bit saw_valid;
        bit saw_err;
        saw_valid = 1'b0;
        saw_err   = 1'b0;
        write_pred(4'd5, 4'd6);
        write_pred(4'd6, 4'd5);
        do_start(4'd10, 4'd5);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
            if (err) saw_err = 1'b1;
        end
        checks++;
        if (saw_err || busy !== 1'b1) begin
            errors++; $display("FAIL cyc_early: early_err=%b busy=%b expected 0/1", saw_err, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || saw_valid) begin
            errors++;
            $display("FAIL cyc_err: err=%b busy=%b valid=%b saw_valid=%b expected 1/0/0/0",
                     err, busy, out_valid, saw_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL cyc_pulse: err=%b expected 0 one cycle later", err);
        end
    endtask

    task automatic test_invalid();
        do_start(4'd0, 4'd14);
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL inv_err: err=%b busy=%b valid=%b expected 1/0/0", err, busy, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_blocked_write();
        out_ready = 1'b1;
        do_start(4'd10, 4'd2);
        write_pred(4'd4, 4'd0);
        collect(1'b0, 16);
        checks++;
        if (beat_n !== 5 || beat_node[0] !== 4'd10 || beat_node[1] !== 4'd4) begin
            errors++;
            $display("FAIL blk_table: n=%0d first=%0d second=%0d expected 5/10/4",
                     beat_n, beat_node[0], beat_node[1]);
        end
    endtask

    task automatic test_reset_mid_emit();
        bit seen;
        seen = 1'b0;
        out_ready = 1'b0;
        do_start(4'd10, 4'd2);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rst_wait: out_valid=0 expected 1 within 10 cycles");
        end
        out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (out_node !== 4'd1) begin
            errors++; $display("FAIL rst_third: node=%0d expected 1", out_node);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_node !== 4'd0 || path_len !== 4'd0) begin
            errors++;
            $display("FAIL rst_async: valid=%b busy=%b node=%0d len=%0d expected 0/0/0/0",
                     out_valid, busy, out_node, path_len);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Zeroed table: pred[1]=0, so 0->1 is a two-beat path
        start = 1'b1; start_node = 4'd0; end_node = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL rst_first_start: busy=%b expected 1", busy);
        end
        collect(1'b0, 10);
        checks++;
        if (beat_n !== 2 || beat_node[0] !== 4'd0 || beat_node[1] !== 4'd1 || beat_len[0] !== 4'd2) begin
            errors++;
            $display("FAIL rst_table: n=%0d nodes=%0d,%0d len=%0d expected 2/0,1/2",
                     beat_n, beat_node[0], beat_node[1], beat_len[0]);
        end
        do_start(4'd3, 4'd3);
        collect(1'b0, 10);
        checks++;
        if (beat_n !== 1 || beat_node[0] !== 4'd3 || beat_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_fresh: n=%0d node=%0d last=%b expected 1/3/1",
                     beat_n, beat_node[0], beat_last[0]);
        end
    endtask

    initial begin
        exp_lin = '{4'd10, 4'd4, 4'd1, 4'd0, 4'd2};
        test_reset();
        test_linear();
        test_backpressure();
        test_trivial();
        test_cycle();
        test_invalid();
        test_blocked_write();
        test_reset_mid_emit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
